// File: rtl/ldtu_gain_sel_fifo.sv
// -----------------------------------------------------------------------------
// ldtu_gain_sel_fifo
//   Single-clock input FIFO / gain selector. The baseline-subtracted x1 and x10
//   samples run through a look-ahead delay line. The output tap is the oldest
//   entry. A tap P samples newer is compared against the x10 saturation
//   threshold. This lets the selector switch to x1 P samples before a
//   saturating sample and hold x1 for Q samples after it. A new saturation
//   inside the window reloads the counter, so the window is extended.
//
// Ports
//   CLK               clock, all logic on the rising edge
//   rst               asynchronous, active-high reset
//   din_valid         sample strobe, both gain inputs valid
//   DATA_gain_01      x1 sample
//   DATA_gain_10      x10 sample
//   SATURATION_value  x10 saturation threshold, applied after shift_gain_10
//   shift_gain_10     right shift applied to the threshold
//   GAIN_SEL_MODE     00 auto, 01 auto with double post window,
//                     10 force x10, 11 force x1
//   win_pre           number of x1 samples before the saturating sample
//   win_post          number of x1 samples after the saturating sample
//   DATA_to_enc       {gain bit (1 = x1), sample} sent to the encoder
//   dout_valid        strobe for DATA_to_enc and baseline_flag
//   baseline_flag     the selected sample is a baseline sample
//   g1_active         the selector FSM is in state G1
// -----------------------------------------------------------------------------
module ldtu_gain_sel_fifo #(
    parameter int NBITS    = 12,
    parameter int DEPTH    = 16,
    parameter int PW       = 4,
    parameter int QW       = 5,
    parameter int BASE_LSB = 6
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [NBITS-1:0] DATA_gain_01,
    input  logic [NBITS-1:0] DATA_gain_10,
    input  logic [NBITS-1:0] SATURATION_value,
    input  logic [1:0]       shift_gain_10,
    input  logic [1:0]       GAIN_SEL_MODE,
    input  logic [PW-1:0]    win_pre,
    input  logic [QW-1:0]    win_post,
    output logic [NBITS:0]   DATA_to_enc,
    output logic             dout_valid,
    output logic             baseline_flag,
    output logic             g1_active
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    // The window length must hold the largest pre value plus twice the
    // largest post value. This sum can exceed QW+1 bits, so one extra bit
    // is used.
    localparam int LW = QW + 2;

    typedef enum logic {G10, G1} state_t;

    logic [NBITS-1:0] sr1  [DEPTH];
    logic [NBITS-1:0] sr10 [DEPTH];
    logic [FW-1:0]    fill_cnt;
    logic             filled;
    logic [NBITS-1:0] sat_val;
    state_t           state;
    logic [LW-1:0]    cnt;

    logic [AW-1:0]    p_len;
    logic [NBITS-1:0] ref_x10;
    logic             sat;
    logic [LW-1:0]    q_len;
    logic [LW-1:0]    l_len;
    logic             sel_x1;
    logic [NBITS:0]   next_data;
    logic             out_strobe;

    assign filled     = (fill_cnt == FW'(DEPTH));
    assign out_strobe = din_valid && filled;
    assign g1_active  = (state == G1);

    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves it unassigned and no latch can be inferred.
    always_comb begin
        p_len     = AW'(win_pre);
        ref_x10   = '0;
        sat       = 1'b0;
        q_len     = LW'(win_post);
        l_len     = '0;
        sel_x1    = 1'b0;
        next_data = '0;

        // The look-ahead cannot reach past the newest entry.
        if (int'(win_pre) > DEPTH - 1)
            p_len = AW'(DEPTH - 1);

        ref_x10 = sr10[AW'(DEPTH - 1) - p_len];
        sat     = !GAIN_SEL_MODE[1] && (ref_x10 >= sat_val);

        if (GAIN_SEL_MODE == 2'b01)
            q_len = LW'(win_post) << 1;
        l_len = LW'(p_len) + q_len;

        case (GAIN_SEL_MODE)
            2'b11:   sel_x1 = 1'b1;
            2'b10:   sel_x1 = 1'b0;
            default: sel_x1 = (state == G1) || sat;
        endcase

        next_data = {sel_x1, sel_x1 ? sr1[DEPTH-1] : sr10[DEPTH-1]};
    end

    // NOTE: sequential state uses non-blocking assignments only. All reads
    // in this block (output tap, look-ahead tap, cnt) therefore see the
    // values from before the edge.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            // NOTE: the delay lines are plain flops and are cleared on reset
            // with the rest of the state. A refill is still required before
            // any output is produced.
            for (int i = 0; i < DEPTH; i++) begin
                sr1[i]  <= '0;
                sr10[i] <= '0;
            end
            fill_cnt      <= '0;
            sat_val       <= '1;
            state         <= G10;
            cnt           <= '0;
            DATA_to_enc   <= '0;
            dout_valid    <= 1'b0;
            baseline_flag <= 1'b0;
        end else begin
            sat_val    <= SATURATION_value >> shift_gain_10;
            dout_valid <= 1'b0;

            if (din_valid) begin
                sr1[0]  <= DATA_gain_01;
                sr10[0] <= DATA_gain_10;
                for (int i = 1; i < DEPTH; i++) begin
                    sr1[i]  <= sr1[i-1];
                    sr10[i] <= sr10[i-1];
                end
                if (!filled)
                    fill_cnt <= fill_cnt + 1'b1;
            end

            if (out_strobe) begin
                DATA_to_enc   <= next_data;
                dout_valid    <= 1'b1;
                // In the forced modes the gain bit is constant, so it is
                // excluded from the baseline test.
                baseline_flag <= GAIN_SEL_MODE[1] ? ~|next_data[NBITS-1:BASE_LSB]
                                                  : ~|next_data[NBITS:BASE_LSB];
            end

            // cnt holds the number of x1 samples still owed after the
            // current one.
            if (GAIN_SEL_MODE[1]) begin
                state <= G10;
                cnt   <= '0;
            end else if (out_strobe) begin
                case (state)
                    G10: begin
                        if (sat && (l_len != '0)) begin
                            state <= G1;
                            cnt   <= l_len;
                        end
                    end
                    G1: begin
                        if (sat) begin
                            cnt <= l_len;
                        end else if (cnt == LW'(1)) begin
                            state <= G10;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ldtu_gain_sel_fifo.sv
// -----------------------------------------------------------------------------
// tb_ldtu_gain_sel_fifo
//   Directed scoreboard bench for ldtu_gain_sel_fifo.
//   When a strobe should produce an output, send() pushes the expected word.
//   The expected gain comes from the hand-given window [win_lo, win_hi].
//   A separate monitor pops and compares on every dout_valid, one clock
//   after the strobe.
// -----------------------------------------------------------------------------
module tb_ldtu_gain_sel_fifo;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic [11:0] DATA_gain_01 = '0;
    logic [11:0] DATA_gain_10 = '0;
    logic [11:0] SATURATION_value = 12'hFFF;
    logic [1:0]  shift_gain_10 = 2'b00;
    logic [1:0]  GAIN_SEL_MODE = 2'b00;
    logic [3:0]  win_pre = 4'd3;
    logic [4:0]  win_post = 5'd8;
    logic [12:0] DATA_to_enc;
    logic        dout_valid;
    logic        baseline_flag;
    logic        g1_active;

    ldtu_gain_sel_fifo dut (
        .CLK              (CLK),
        .rst              (rst),
        .din_valid        (din_valid),
        .DATA_gain_01     (DATA_gain_01),
        .DATA_gain_10     (DATA_gain_10),
        .SATURATION_value (SATURATION_value),
        .shift_gain_10    (shift_gain_10),
        .GAIN_SEL_MODE    (GAIN_SEL_MODE),
        .win_pre          (win_pre),
        .win_post         (win_post),
        .DATA_to_enc      (DATA_to_enc),
        .dout_valid       (dout_valid),
        .baseline_flag    (baseline_flag),
        .g1_active        (g1_active)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [12:0] data;
        logic        bl;
        logic        g1;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [11:0] hx1  [0:255];
    logic [11:0] hx10 [0:255];
    int          k_cnt = 0;
    int          win_lo = -1;
    int          win_hi = -2;
    logic        out_due = 1'b0;
    int          x1_base = 100;
    int          x10_base = 0;
    logic [11:0] ovr[int];
    logic [1:0]  mode_at[int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output for sample s under mode m. The gain follows the
    // hand-given window, and G1 lasts while more x1 samples are owed.
    function automatic exp_t mk_exp(input int s, input logic [1:0] m);
        exp_t e;
        logic g;
        if (m == 2'b11)      g = 1'b1;
        else if (m == 2'b10) g = 1'b0;
        else                 g = (s >= win_lo) && (s <= win_hi);
        e.data = {g, g ? hx1[s] : hx10[s]};
        e.g1   = !m[1] && (s >= win_lo) && (s < win_hi);
        e.bl   = m[1] ? (e.data[11:6] == 6'd0) : (e.data[12:6] == 7'd0);
        return e;
    endfunction

    // Called at posedge+1. Returns at posedge+1 after the strobe edge plus gap idle cycles.
    task automatic send(input logic [11:0] x1, input logic [11:0] x10, input int gap);
        hx1[k_cnt]   = x1;
        hx10[k_cnt]  = x10;
        DATA_gain_01 = x1;
        DATA_gain_10 = x10;
        din_valid    = 1'b1;
        out_due      = (k_cnt >= DEPTH);
        if (out_due)
            sb.push_back(mk_exp(k_cnt - DEPTH, GAIN_SEL_MODE));
        @(posedge CLK);
        #1;
        din_valid = 1'b0;
        out_due   = 1'b0;
        k_cnt++;
        if (gap > 0) begin
            repeat (gap) @(posedge CLK);
            #1;
        end
    endtask

    task automatic run(input int n, input int gapmax);
        for (int k = 0; k < n; k++) begin
            logic [11:0] x10v;
            if (mode_at.exists(k))
                GAIN_SEL_MODE = mode_at[k];
            x10v = ovr.exists(k) ? ovr[k] : 12'(x10_base + k);
            send(12'(x1_base + k), x10v, (gapmax > 0) ? (k % (gapmax + 1)) : 0);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        check({tag, "_sb_drained"}, sb.size(), 0);
        sb.delete();
        #2 rst = 1'b1;
        din_valid = 1'b0;
        #1;
        check({tag, "_rst_dout_valid"}, dout_valid, 0);
        check({tag, "_rst_data"}, DATA_to_enc, 0);
        check({tag, "_rst_baseline"}, baseline_flag, 0);
        check({tag, "_rst_g1_active"}, g1_active, 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        rst   = 1'b0;
        k_cnt = 0;
        @(posedge CLK);
        #1;
    endtask

    // Monitor: a strobe that should produce an output must give dout_valid
    // one clock later. Every dout_valid pops and compares one expected word.
    initial begin
        logic due;
        exp_t e;
        forever begin
            @(posedge CLK);
            due = din_valid && out_due;
            @(negedge CLK);
            if (due || dout_valid)
                check("dout_valid", dout_valid, due);
            if (dout_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got data 0x%0h, no output expected at %0t",
                             DATA_to_enc, $time);
                end else begin
                    e = sb.pop_front();
                    check("data", DATA_to_enc, e.data);
                    check("baseline_flag", baseline_flag, e.bl);
                    check("g1_active", g1_active, e.g1);
                end
            end else if (due && sb.size() > 0) begin
                sb.delete(0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: fill latency and plain x10 path; outputs 0x000.. with baseline set.
        do_reset("t1");
        run(20, 0);

        // 2: single saturation at sample 40 -> x1 for 37..48.
        SATURATION_value = 12'h800;
        ovr[40] = 12'hFFF;
        win_lo = 37; win_hi = 48;
        do_reset("t2");
        run(70, 0);

        // 3: retrigger at sample 45 extends the window to 53.
        ovr[45] = 12'hFFF;
        win_lo = 37; win_hi = 53;
        do_reset("t3");
        run(75, 0);

        // 4: double post window. Threshold 0x800>>1 = 0x400: 0x400 triggers, 0x3FF does not.
        ovr.delete();
        GAIN_SEL_MODE = 2'b01;
        shift_gain_10 = 2'd1;
        ovr[20] = 12'h3FF;
        ovr[40] = 12'h400;
        win_lo = 37; win_hi = 56;
        do_reset("t4");
        run(80, 0);

        // 5: force x1, then auto, then force x10 in the middle of a window, with gaps.
        ovr.delete();
        shift_gain_10 = 2'd0;
        GAIN_SEL_MODE = 2'b11;
        x1_base  = 0;
        x10_base = 16;
        ovr[40] = 12'hFFF;
        mode_at[46] = 2'b00;
        mode_at[58] = 2'b10;
        win_lo = 37; win_hi = 48;
        do_reset("t5");
        run(70, 1);
        mode_at.delete();

        // 7: zero pre/post -> exactly one x1 sample, G1 never entered.
        ovr.delete();
        GAIN_SEL_MODE = 2'b00;
        x1_base  = 100;
        x10_base = 0;
        win_pre  = 4'd0;
        win_post = 5'd0;
        ovr[20] = 12'hFFF;
        win_lo = 20; win_hi = 20;
        do_reset("t7");
        run(40, 0);

        // 6: reset inside a window with gapped strobes, then refill from scratch.
        ovr.delete();
        win_pre  = 4'd3;
        win_post = 5'd8;
        ovr[40] = 12'hFFF;
        win_lo = 37; win_hi = 48;
        do_reset("t6a");
        run(56, 2);
        ovr.delete();
        win_lo = -1; win_hi = -2;
        x10_base = 32;
        do_reset("t6b");
        run(26, 3);

        repeat (2) @(negedge CLK);
        check("sb_empty_at_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
